// File: rtl/rule_feeder_pkg.sv
// Shared types and constants for the rule feeder and its helpers.
package rule_feeder_pkg;

  // Width of one rule ID; an ID of 0 marks an empty lane.
  localparam int RULE_AWIDTH = 16;

  // Default number of rule-ID lanes per matcher bundle.
  localparam int DEF_NUM_LANES = 8;

  // Per-bundle metadata captured alongside the lanes at accept time.
  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic        tcp;
    logic        last;
  } feeder_meta_t;

  // Feeder control states: nothing held, or a bundle being scanned.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/lane_prio_enc.sv
// Lowest-index priority encoder over the pending-lane mask.
// Also reports whether at most one lane is still pending, which is the
// cycle on which the feeder can take the next bundle without a bubble.
module lane_prio_enc #(
  parameter int NUM_LANES = 8,
  parameter int IDX_W     = 3
) (
  input  logic [NUM_LANES-1:0] mask,
  output logic [IDX_W-1:0]     idx,
  output logic [NUM_LANES-1:0] onehot,
  output logic                 any,
  output logic                 at_most_one
);

  localparam logic [NUM_LANES-1:0] ONE = {{(NUM_LANES-1){1'b0}}, 1'b1};

  // Two's complement isolates the lowest set bit.
  assign onehot      = mask & (~mask + ONE);
  assign any         = |mask;
  // Clearing the lowest set bit leaves nothing when zero or one bit is set.
  assign at_most_one = ((mask & (mask - ONE)) == '0);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rule_feeder.sv
// Serializes multi-lane rule-ID bundles into a one-rule-per-cycle stream
// for rule_unit, skipping empty lanes, honouring downstream stall and
// flagging end of packet on the cycle the last bundle of a packet drains.
module rule_feeder
  import rule_feeder_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int CNT_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_LANES*RULE_AWIDTH-1:0] in_rules,
  input  logic [15:0]                      in_src_port,
  input  logic [15:0]                      in_dst_port,
  input  logic                             in_tcp,
  input  logic                             in_last,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             stall,
  output logic [RULE_AWIDTH-1:0]           out_rule_data,
  output logic                             out_rule_valid,
  output logic [15:0]                      out_src_port,
  output logic [15:0]                      out_dst_port,
  output logic                             out_tcp,
  output logic                             out_eop,
  output logic [CNT_WIDTH-1:0]             stat_bundles,
  output logic [CNT_WIDTH-1:0]             stat_rules
);

  localparam int IDX_W = $clog2(NUM_LANES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  feeder_state_t state, next_state;

  logic [NUM_LANES-1:0][RULE_AWIDTH-1:0] in_lanes;
  logic [NUM_LANES-1:0][RULE_AWIDTH-1:0] hold_lanes;
  feeder_meta_t                          in_meta;
  feeder_meta_t                          hold_meta;
  logic [NUM_LANES-1:0]                  mask;
  logic [NUM_LANES-1:0]                  in_mask;
  logic [NUM_LANES-1:0]                  sel_onehot;
  logic [IDX_W-1:0]                      sel_idx;
  logic                                  mask_any;
  logic                                  mask_le1;

  logic ready;
  logic accept;
  logic advance;
  logic issue;
  logic exhausted;

  assign in_lanes = in_rules;
  assign in_meta  = '{src_port: in_src_port, dst_port: in_dst_port,
                      tcp: in_tcp, last: in_last};
  assign in_ready = ready;

  // Pending mask of the incoming bundle: one bit per non-empty lane.
  always_comb begin
    in_mask = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      in_mask[i] = (in_lanes[i] != '0);
    end
  end

  lane_prio_enc #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (IDX_W)
  ) u_enc (
    .mask        (mask),
    .idx         (sel_idx),
    .onehot      (sel_onehot),
    .any         (mask_any),
    .at_most_one (mask_le1)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next state and per-cycle control: readiness, accept, issue, drain.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    advance    = 1'b0;
    issue      = 1'b0;
    exhausted  = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
      end
      ST_SCAN: begin
        if (!stall) begin
          advance   = 1'b1;
          issue     = mask_any;
          // Zero or one pending bit means this cycle drains the bundle.
          exhausted = mask_le1;
          ready     = mask_le1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    // Readiness is withheld while reset is asserted.
    ready  = ready & rst_n;
    accept = in_valid & ready;
    if (accept)         next_state = ST_SCAN;
    else if (exhausted) next_state = ST_IDLE;
  end

  // Bundle payload and metadata, captured only when a bundle is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_lanes <= in_lanes;
      hold_meta  <= in_meta;
    end
  end

  // Pending mask, registered outputs toward rule_unit, and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask           <= '0;
      out_rule_data  <= '0;
      out_rule_valid <= 1'b0;
      out_src_port   <= '0;
      out_dst_port   <= '0;
      out_tcp        <= 1'b0;
      out_eop        <= 1'b0;
      stat_bundles   <= '0;
      stat_rules     <= '0;
    end else begin
      out_rule_data  <= '0;
      out_rule_valid <= 1'b0;
      out_eop        <= 1'b0;
      if (advance) begin
        out_src_port <= hold_meta.src_port;
        out_dst_port <= hold_meta.dst_port;
        out_tcp      <= hold_meta.tcp;
        mask         <= mask & ~sel_onehot;
        if (issue) begin
          out_rule_data  <= hold_lanes[sel_idx];
          out_rule_valid <= 1'b1;
          stat_rules     <= stat_rules + CNT_ONE;
        end
        if (exhausted) out_eop <= hold_meta.last;
      end
      // A new bundle only lands when the previous one has drained.
      if (accept) begin
        mask         <= in_mask;
        stat_bundles <= stat_bundles + CNT_ONE;
      end
    end
  end

endmodule
